// File: rtl/clock_divider_strobe.sv
// clock_divider_strobe: programmable tick/divclk generator from masterclk,
// with divisor reloads applied only on period boundaries and acknowledged.
module clock_divider_strobe #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 50
) (
    input  logic             masterclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_value,
    input  logic             div_load,
    input  logic             clr_count,
    output logic             div_ack,
    output logic             tick,
    output logic             divclk,
    output logic             running,
    output logic [31:0]      tick_count
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_div_q, pend_div_d, n_q, n_d;
    logic [CNT_W:0] half_d;
    logic pend_q, pend_d, tick_q, tick_d, divclk_q, divclk_d, ack_q, ack_d;
    logic wrap, apply;
    logic [31:0] tick_count_q, tick_count_d;

    always_ff @(posedge masterclk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= DEFAULT_DIV;
            pend_q       <= 1'b0;
            pend_div_q   <= '0;
            tick_q       <= 1'b0;
            divclk_q     <= 1'b0;
            ack_q        <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            pend_q       <= pend_d;
            pend_div_q   <= pend_div_d;
            tick_q       <= tick_d;
            divclk_q     <= divclk_d;
            ack_q        <= ack_d;
            tick_count_q <= tick_count_d;
        end
    end

    always_comb state_d = enable ? RUN : IDLE;

    // Outputs are registered from next-state values so they line up with the count they describe.
    always_comb begin
        n_q          = (div_q == '0) ? CNT_W'(1) : div_q;
        wrap         = (state_q == RUN) && enable && (cnt_q == n_q - 1'b1);
        apply        = ((state_q == IDLE) && pend_q) || (wrap && (pend_q || div_load));
        pend_div_d   = div_load ? div_value : pend_div_q;
        div_d        = apply ? pend_div_d : div_q;
        pend_d       = apply ? 1'b0 : (pend_q || div_load);
        ack_d        = apply;
        cnt_d        = ((state_q == RUN) && (state_d == RUN) && !wrap) ? cnt_q + 1'b1 : '0;
        n_d          = (div_d == '0) ? CNT_W'(1) : div_d;
        half_d       = ({1'b0, n_d} + 1'b1) >> 1;
        tick_d       = (state_d == RUN) && (cnt_d == '0);
        divclk_d     = (state_d == RUN) && ({1'b0, cnt_d} < half_d);
        tick_count_d = clr_count ? '0 : tick_count_q + {31'd0, tick_q};
    end

    assign div_ack    = ack_q;
    assign tick       = tick_q;
    assign divclk     = divclk_q;
    assign running    = (state_q == RUN);
    assign tick_count = tick_count_q;
endmodule

// File: tb/tb_clock_divider_strobe.sv
// tb_clock_divider_strobe: vector table, directed corner sequences and random
// stimulus checked against a timestamp-based period model.
module tb_clock_divider_strobe;
    logic clk = 0, rst = 1, en = 0, ld = 0, clr = 0;
    logic [15:0] dv = '0;
    logic ack, tick, divclk, running;
    logic [31:0] tcnt;
    int n_chk = 0, n_bad = 0;

    always #5 clk = ~clk;

    clock_divider_strobe dut (
        .masterclk(clk), .reset(rst), .enable(en), .div_value(dv), .div_load(ld),
        .clr_count(clr), .div_ack(ack), .tick(tick), .divclk(divclk),
        .running(running), .tick_count(tcnt)
    );

    typedef struct {
        logic en, ld;
        logic [15:0] dv;
        logic clr;
        logic tick, divclk, ack, run;
    } vec_t;
    vec_t vt[12];

    // Model: a period is described by the cycle index at which it started.
    bit m_run, m_pend, m_ack, e_tick, e_divclk;
    int m_t = 0, m_start = 0, m_div = 50, m_pdiv = 0;
    logic [31:0] m_cnt = '0;

    function automatic int eff(int d);
        return d == 0 ? 1 : d;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_run = 0; m_pend = 0; m_ack = 0; m_div = 50; m_cnt = '0; m_start = 0;
        end else begin
            m_cnt = clr ? 32'd0 : m_cnt + (e_tick ? 32'd1 : 32'd0);
            m_ack = 0;
            if (m_run && en && (m_t + 1 - m_start == eff(m_div))) begin
                m_start = m_t + 1;
                if (ld || m_pend) begin
                    m_div = ld ? int'(dv) : m_pdiv; m_ack = 1; m_pend = 0;
                end
            end else if (!m_run && m_pend) begin
                m_div = ld ? int'(dv) : m_pdiv; m_ack = 1; m_pend = 0;
            end else if (ld) begin
                m_pend = 1; m_pdiv = int'(dv);
            end
            if (!m_run && en) m_start = m_t + 1;
            m_run = en;
        end
        m_t++;
        e_tick   = m_run && (m_t == m_start);
        e_divclk = m_run && ((m_t - m_start) < (eff(m_div) + 1) / 2);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("tick", {31'd0, tick}, {31'd0, e_tick});
        chk("divclk", {31'd0, divclk}, {31'd0, e_divclk});
        chk("div_ack", {31'd0, ack}, {31'd0, m_ack});
        chk("running", {31'd0, running}, {31'd0, m_run});
        chk("tick_count", tcnt, m_cnt);
    endtask

    task automatic do_reset();
        rst = 1; cyc(); rst = 0;
    endtask

    initial begin
        int nt, last;
        logic [31:0] tm, am, pat;
        vt[0]  = '{0, 1, 16'd4, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 16'd0, 0, 0, 0, 1, 0};
        vt[2]  = '{1, 0, 16'd0, 0, 1, 1, 0, 1};
        vt[3]  = '{1, 0, 16'd0, 0, 0, 1, 0, 1};
        vt[4]  = '{1, 0, 16'd0, 0, 0, 0, 0, 1};
        vt[5]  = '{1, 0, 16'd0, 0, 0, 0, 0, 1};
        vt[6]  = '{1, 0, 16'd0, 0, 1, 1, 0, 1};
        vt[7]  = '{1, 0, 16'd0, 0, 0, 1, 0, 1};
        vt[8]  = '{1, 0, 16'd0, 0, 0, 0, 0, 1};
        vt[9]  = '{1, 0, 16'd0, 0, 0, 0, 0, 1};
        vt[10] = '{1, 0, 16'd0, 0, 1, 1, 0, 1};
        vt[11] = '{0, 0, 16'd0, 0, 0, 0, 0, 0};

        // reset, then default divisor of 50
        rst = 1; en = 0;
        repeat (3) cyc();
        chk("rst_outs", {28'd0, ack, tick, divclk, running}, 32'd0);
        chk("rst_count", tcnt, 32'd0);
        rst = 0; cyc();
        chk("idle_outs", {28'd0, ack, tick, divclk, running}, 32'd0);
        en = 1; nt = 0; last = -1;
        for (int i = 0; i < 101; i++) begin
            cyc();
            if (tick) begin
                if (nt == 0) chk("first_tick", i, 0);
                else chk("gap50", i - last, 50);
                last = i; nt++;
            end
        end
        chk("n_ticks50", nt, 3);

        // table: load 4 in IDLE, run, drop enable
        en = 0; do_reset();
        for (int i = 0; i < 12; i++) begin
            en = vt[i].en; ld = vt[i].ld; dv = vt[i].dv; clr = vt[i].clr;
            cyc();
            chk($sformatf("vec%0d", i), {28'd0, tick, divclk, ack, running},
                {28'd0, vt[i].tick, vt[i].divclk, vt[i].ack, vt[i].run});
        end
        ld = 0;

        // load 3 mid-period of a 5-cycle run
        do_reset();
        ld = 1; dv = 5; cyc(); ld = 0; cyc();
        en = 1; tm = '0; am = '0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            tm[i] = tick; am[i] = ack;
            ld = (i == 1); dv = 3;
        end
        chk("n5to3_ticks", tm, 32'h921);
        chk("n5to3_ack", am, 32'h20);

        // divisor 0 and 1 hold both strobes high; divisor 7 splits 4/3
        en = 0; cyc();
        ld = 1; dv = 0; cyc(); ld = 0; cyc();
        en = 1;
        for (int i = 0; i < 6; i++) begin cyc(); chk("n0_hold", {30'd0, tick, divclk}, 32'd3); end
        ld = 1; dv = 1; cyc(); ld = 0;
        for (int i = 0; i < 4; i++) begin cyc(); chk("n1_hold", {30'd0, tick, divclk}, 32'd3); end
        ld = 1; dv = 7; cyc(); ld = 0;
        pat = '0; pat[0] = divclk;
        chk("n7_ack", {31'd0, ack}, 32'd1);
        for (int i = 1; i < 7; i++) begin cyc(); pat[i] = divclk; end
        chk("n7_divclk", pat, 32'h0F);
        cyc();
        chk("n7_wrap_tick", {31'd0, tick}, 32'd1);

        // drop enable at count 2, then re-enable
        en = 0; do_reset();
        ld = 1; dv = 4; cyc(); ld = 0; cyc();
        en = 1; repeat (3) cyc();
        en = 0; cyc();
        chk("drop_en", {29'd0, running, tick, divclk}, 32'd0);
        en = 1; cyc();
        chk("reen_tick", {30'd0, running, tick}, 32'd3);

        // clear coincident with a tick
        clr = 1; cyc(); clr = 0;
        chk("clr_on_tick", tcnt, 32'd0);

        // reset mid-period with a pending load
        repeat (5) cyc();
        ld = 1; dv = 9; cyc(); ld = 0;
        rst = 1; cyc(); rst = 0;
        chk("rst_pend_ack", {31'd0, ack}, 32'd0);
        chk("rst_pend_cnt", tcnt, 32'd0);
        nt = 0; last = -1; am = '0;
        for (int i = 0; i < 52; i++) begin
            cyc();
            if (ack) am = am + 1;
            if (tick) begin
                if (nt > 0) chk("rst_gap50", i - last, 50);
                last = i; nt++;
            end
        end
        chk("rst_no_ack", am, 32'd0);
        chk("rst_n_ticks", nt, 2);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom % 10) != 0;
            ld  = ($urandom % 16) == 0;
            dv  = 16'($urandom_range(0, 9));
            clr = ($urandom % 50) == 0;
            rst = ($urandom % 300) == 0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
